// File: rtl/keystone_pkg.sv
// Shared types for the keystone video stream: beat payload and transmit FSM states.
// Beat layout is {data, user(SOF), last(EOL)}.
package keystone_pkg;
  localparam int PIX_DATA_W = 64;
  localparam int DIM_W      = 12;

  typedef struct packed {
    logic [PIX_DATA_W-1:0] data;
    logic                  user;
    logic                  last;
  } axis_beat_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } tx_state_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer (output register + overflow register); latency 1, 1 beat/cycle.
// in_ready is registered: drops once the overflow slot fills under out_ready=0.
module axis_skid_buffer
  import keystone_pkg::*;
#(
  parameter type T = axis_beat_t
) (
  input  logic clock,
  input  logic reset,
  input  logic clock_en,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_beat,
  output logic out_valid,
  input  logic out_ready,
  output T     out_beat,
  output logic empty
);
  T     r_out;
  T     r_skid;
  logic r_out_vld;
  logic r_skid_vld;
  logic w_push;

  assign in_ready  = ~r_skid_vld;
  assign out_valid = r_out_vld;
  assign out_beat  = r_out;
  assign empty     = ~r_out_vld;
  assign w_push    = in_valid & ~r_skid_vld & clock_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (clock_en) begin
      if (!r_out_vld || out_ready) begin
        // Output slot frees up: refill from overflow first to keep order.
        if (r_skid_vld) begin
          r_out      <= r_skid;
          r_out_vld  <= 1'b1;
          r_skid_vld <= 1'b0;
        end else begin
          r_out_vld <= w_push;
          if (w_push) r_out <= in_beat;
        end
      end else if (w_push) begin
        r_skid     <= in_beat;
        r_skid_vld <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/axis_video_tx.sv
// Frames upstream pixel beats into tuser/tlast-tagged AXI-Stream video; one frame per start.
// Stream outputs come from the skid buffer (latency 1); pix_ready_out follows skid space.
module axis_video_tx #(
  parameter int DATA_W = 64,
  parameter int DIM_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clock_en,
  input  logic [DIM_W-1:0]  cfg_width_beats,
  input  logic [DIM_W-1:0]  cfg_height_lines,
  input  logic              start,
  input  logic [DATA_W-1:0] pix_data_in,
  input  logic              pix_valid_in,
  output logic              pix_ready_out,
  output logic [DATA_W-1:0] tdata_out,
  output logic              tvalid_out,
  input  logic              tready_in,
  output logic              tuser_out,
  output logic              tlast_out,
  output logic              busy,
  output logic              frame_done
);
  import keystone_pkg::*;

  tx_state_t        r_state;
  logic [DIM_W-1:0] r_col;
  logic [DIM_W-1:0] r_line;
  logic [DIM_W-1:0] r_width;
  logic [DIM_W-1:0] r_height;
  logic             r_frame_done;

  axis_beat_t w_in_beat;
  axis_beat_t w_out_beat;
  logic       w_skid_in_rdy;
  logic       w_skid_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_col_last;
  logic       w_line_last;

  assign w_col_last    = (r_col == r_width - DIM_W'(1));
  assign w_line_last   = (r_line == r_height - DIM_W'(1));
  assign pix_ready_out = (r_state == ACTIVE) & w_skid_in_rdy;
  assign w_push        = pix_valid_in & pix_ready_out & clock_en;
  assign w_pop         = tvalid_out & tready_in & clock_en;

  assign w_in_beat.data = pix_data_in;
  assign w_in_beat.user = (r_col == '0) && (r_line == '0);
  assign w_in_beat.last = w_col_last;

  axis_skid_buffer #(.T(axis_beat_t)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .clock_en  (clock_en),
    .in_valid  (pix_valid_in & (r_state == ACTIVE)),
    .in_ready  (w_skid_in_rdy),
    .in_beat   (w_in_beat),
    .out_valid (tvalid_out),
    .out_ready (tready_in),
    .out_beat  (w_out_beat),
    .empty     (w_skid_empty)
  );

  assign tdata_out  = w_out_beat.data;
  assign tuser_out  = w_out_beat.user;
  assign tlast_out  = w_out_beat.last;
  assign busy       = (r_state != IDLE) | ~w_skid_empty;
  assign frame_done = r_frame_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_line       <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_frame_done <= 1'b0;
    end else if (clock_en) begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && (cfg_width_beats != '0) && (cfg_height_lines != '0)) begin
            r_width  <= cfg_width_beats;
            r_height <= cfg_height_lines;
            r_col    <= '0;
            r_line   <= '0;
            r_state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_push) begin
            if (w_col_last) begin
              r_col <= '0;
              if (w_line_last) r_state <= DRAIN;
              else             r_line  <= r_line + DIM_W'(1);
            end else begin
              r_col <= r_col + DIM_W'(1);
            end
          end
        end
        DRAIN: begin
          // Popping while the overflow slot is empty means the final beat leaves now.
          if (w_pop && w_skid_in_rdy) begin
            r_state      <= IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
